// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, DATA} arb_state_e;

  // Read data returned to the owner when the watchdog abandons a transfer.
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Stall watchdog for the arbiter: counts cycles a transfer waits on
// mem_ready and flags expiry on the LIMIT-th waiting cycle.
module mem_arb_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  assign expired = en && (cnt == CW'(LIMIT - 1));

  // Wait counter: held at zero outside a transfer, so every entry starts fresh.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (en && !expired)   cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter: instruction fetch vs. data load/store.
// Data has priority, but fetch is granted after STARVE_MAX consecutive data
// grants it has sat through. Requests are registered onto mem_* and held
// until mem_ready; completion is a one-cycle if_valid / d_done pulse.
// Optional: define MEM_ARB_TIMEOUT_EN to add a mem_ready watchdog that
// abandons a stuck transfer after TIMEOUT_CYCLES and raises err.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int STARVE_MAX     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  output logic                if_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_done,
  output logic                d_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [DATA_W-1:0] TO_RDATA = DATA_W'(TIMEOUT_RDATA);

  arb_state_e    state;
  logic [SW-1:0] starve_cnt;
  logic          d_grant;
  logic          timeout;

  assign if_stall = if_req & ~if_valid;
  assign d_stall  = d_req  & ~d_done;

  // Data wins unless fetch has already waited out STARVE_MAX data grants.
  assign d_grant = d_req && ((starve_cnt < SW'(STARVE_MAX)) || !if_req);

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (state == IDLE),
    .en      (mem_req && !mem_ready),
    .expired (timeout)
  );
`else
  // Watchdog compiled out: never expires.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  // Arbitration FSM with registered memory-side request and completion pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_valid   <= 1'b0;
      d_done     <= 1'b0;
      err        <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if_valid <= 1'b0;
      d_done   <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (d_grant) begin
            state     <= DATA;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_be    <= d_be;
            // Only count grants that actually made fetch wait.
            if (!if_req)                              starve_cnt <= '0;
            else if (starve_cnt != SW'(STARVE_MAX))   starve_cnt <= starve_cnt + 1'b1;
          end else if (if_req) begin
            state      <= FETCH;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_be     <= '1;
            starve_cnt <= '0;
          end
        end
        FETCH, DATA: begin
          if (mem_ready || timeout) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            err     <= timeout;
            if (state == FETCH) begin
              if_valid <= 1'b1;
              if_rdata <= timeout ? TO_RDATA : mem_rdata;
            end else begin
              d_done <= 1'b1;
              // Stores leave the last load data in place.
              if (timeout)      d_rdata <= TO_RDATA;
              else if (!mem_we) d_rdata <= mem_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// random traffic, all checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int STARVE = 4;
  localparam int TO_CYC = 8;

  logic        clk = 1'b0, reset = 1'b0;
  logic        if_req, if_valid, if_stall, d_req, d_we, d_done, d_stall;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be, mem_be;
  logic        mem_req, mem_we, mem_ready, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
  );

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; } dreq_t;
  dreq_t       dq[$];
  logic [31:0] iq[$];
  bit d_b2b, i_b2b, rand_wait;
  int fixed_wait, cur_wait, mcnt;
  int tests = 0, fails = 0, cyc;

  // reference model: one outstanding transfer, who owns it, and expected outputs
  bit          busy, own_d, exp_iv, exp_dd, exp_err;
  logic        t_we;
  logic [3:0]  t_be;
  logic [31:0] t_addr, t_wdata, exp_ird, exp_drd;
  int          streak, wcnt;

  // per-scenario event log observed from the DUT
  int dd_cyc, iv_cyc, err_cyc, n_dd, n_iv, d_before, n_frise, req_cyc;
  logic [31:0] dd_rdata;
  bit prev_mem_req;

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    busy = 0; exp_iv = 0; exp_dd = 0; exp_err = 0;
    exp_ird = '0; exp_drd = '0; streak = 0; wcnt = 0;
  endtask

  task automatic clear_log();
    cyc = 0; dd_cyc = -1; iv_cyc = -1; err_cyc = -1; n_dd = 0; n_iv = 0;
    d_before = 0; n_frise = 0; req_cyc = 0; dd_rdata = '0;
  endtask

  task automatic load_d();
    dreq_t r;
    r = dq.pop_front();
    d_req = 1; d_we = r.we; d_addr = r.addr; d_wdata = r.wdata; d_be = r.be;
  endtask

  task automatic drop_d();
    d_req = 0; d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
  endtask

  task automatic drop_i();
    if_req = 0; if_addr = $urandom;
  endtask

  // requesters: hold req until done, release in the done cycle unless back-to-back
  task automatic agents();
    if (d_done) begin
      if (d_b2b && dq.size() > 0) load_d(); else drop_d();
    end else if (!d_req && dq.size() > 0) load_d();
    if (if_valid) begin
      if (i_b2b && iq.size() > 0) begin if_req = 1; if_addr = iq.pop_front(); end
      else drop_i();
    end else if (!if_req && iq.size() > 0) begin if_req = 1; if_addr = iq.pop_front(); end
  endtask

  // memory: fixed or random wait states, garbage data except on the ready cycle
  task automatic respond();
    if (!mem_req) begin
      mcnt = 0; mem_ready = 0;
    end else begin
      if (mcnt == 0) cur_wait = rand_wait ? int'($urandom_range(0, 3)) : fixed_wait;
      mem_ready = (mcnt >= cur_wait);
      mcnt = mem_ready ? 0 : mcnt + 1;
    end
    mem_rdata = mem_ready ? rd_of(mem_addr) : $urandom;
  endtask

  // what the upcoming clock edge must do, from the arbitration rules
  task automatic model_edge();
    bit to;
    to = 0; exp_iv = 0; exp_dd = 0; exp_err = 0;
    if (busy) begin
`ifdef MEM_ARB_TIMEOUT_EN
      if (!mem_ready) begin wcnt++; to = (wcnt == TO_CYC); end
`endif
      if (mem_ready || to) begin
        busy = 0; exp_err = to;
        if (own_d) begin
          exp_dd = 1;
          if (to) exp_drd = 32'hDEAD_BEEF;
          else if (!t_we) exp_drd = rd_of(t_addr);
        end else begin
          exp_iv = 1;
          exp_ird = to ? 32'hDEAD_BEEF : rd_of(t_addr);
        end
      end
    end else if (d_req && (streak < STARVE || !if_req)) begin
      busy = 1; own_d = 1; wcnt = 0;
      t_we = d_we; t_addr = d_addr; t_wdata = d_wdata; t_be = d_be;
      streak = if_req ? streak + 1 : 0;
    end else if (if_req) begin
      busy = 1; own_d = 0; wcnt = 0;
      t_we = 0; t_addr = if_addr; t_be = 4'hF;
      streak = 0;
    end
  endtask

  task automatic check_all();
    chk("mem_req", mem_req, busy);
    if (busy) begin
      chk("mem_addr", mem_addr, t_addr);
      chk("mem_we", mem_we, t_we);
      chk("mem_be", mem_be, t_be);
      if (own_d) chk("mem_wdata", mem_wdata, t_wdata);
    end
    chk("if_valid", if_valid, exp_iv);
    chk("d_done", d_done, exp_dd);
    chk("if_rdata", if_rdata, exp_ird);
    chk("d_rdata", d_rdata, exp_drd);
    chk("err", err, exp_err);
    chk("if_stall", if_stall, if_req & ~exp_iv);
    chk("d_stall", d_stall, d_req & ~exp_dd);
  endtask

  task automatic log_events();
    if (d_done) begin n_dd++; if (dd_cyc < 0) dd_cyc = cyc; dd_rdata = d_rdata; end
    if (if_valid) begin n_iv++; if (iv_cyc < 0) iv_cyc = cyc; end
    if (err && err_cyc < 0) err_cyc = cyc;
    if (mem_req) req_cyc++;
    if (mem_req && !prev_mem_req) begin
      if (mem_addr[31]) begin if (n_frise == 0) d_before++; end
      else n_frise++;
    end
    prev_mem_req = mem_req;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk); #1;
    cyc++;
    respond();
    agents();
    #1;
    check_all();
    log_events();
  endtask

  function automatic bit quiet();
    return dq.size() == 0 && iq.size() == 0 && !d_req && !if_req && !busy &&
           !mem_req && !d_done && !if_valid;
  endfunction

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (!quiet() && n < 200) begin step(); n++; end
    chk(tag, 32'(n < 200), 32'd1);
  endtask

  task automatic start();
    clear_log();
    agents();
    #1;
    check_all();
  endtask

  initial begin
    drop_d(); drop_i();
    mem_ready = 0; mem_rdata = '0; mcnt = 0; cur_wait = 0;
    fixed_wait = 0; rand_wait = 0; d_b2b = 0; i_b2b = 0; prev_mem_req = 0;
    model_reset(); clear_log();

    // reset values
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", mem_be, 0);
    @(negedge clk); reset = 1;

    // fetch only, zero wait
    iq.push_back(32'h100);
    start();
    chk("t1_stall_c0", if_stall, 1);
    step();
    chk("t1_mem_req_c1", mem_req, 1);
    chk("t1_mem_addr_c1", mem_addr, 32'h100);
    chk("t1_stall_c1", if_stall, 1);
    step();
    chk("t1_valid_c2", if_valid, 1);
    chk("t1_rdata_c2", if_rdata, rd_of(32'h100));
    chk("t1_stall_c2", if_stall, 0);
    drain("t1_drain");

    // simultaneous fetch and load: data first, fetch granted in the data done cycle
    dq.push_back('{we: 1'b0, addr: 32'h8000_0010, wdata: 32'h0, be: 4'hF});
    iq.push_back(32'h200);
    start();
    drain("t2_drain");
    chk("t2_dd_cyc", dd_cyc, 2);
    chk("t2_iv_cyc", iv_cyc, 4);
    chk("t2_load_data", dd_rdata, rd_of(32'h8000_0010));

    // store with three wait states
    fixed_wait = 3;
    dq.push_back('{we: 1'b1, addr: 32'h8000_0040, wdata: 32'hCAFE_1234, be: 4'b0011});
    start();
    step();
    chk("t3_mem_we", mem_we, 1);
    chk("t3_mem_be", mem_be, 4'b0011);
    drain("t3_drain");
    chk("t3_req_cycles", req_cyc, 4);
    chk("t3_dd_cyc", dd_cyc, 5);
    chk("t3_rdata_kept", d_rdata, rd_of(32'h8000_0010));

    // starvation: data streams back-to-back while fetch waits
    fixed_wait = 0; d_b2b = 1;
    for (int i = 0; i < 10; i++)
      dq.push_back('{we: 1'(i % 2), addr: 32'h8000_1000 + 32'(4 * i), wdata: $urandom, be: 4'($urandom)});
    iq.push_back(32'h400);
    start();
    drain("t4_drain");
    chk("t4_data_before_fetch", d_before, STARVE);
    chk("t4_data_done", n_dd, 10);
    chk("t4_fetch_valid", n_iv, 1);
    d_b2b = 0;

    // reset in the middle of a data transfer
    fixed_wait = 10;
    dq.push_back('{we: 1'b0, addr: 32'h8000_0080, wdata: 32'h0, be: 4'hF});
    start();
    step(); step();
    chk("t5_busy_before", mem_req, 1);
    reset = 0;
    #1;
    chk("t5_req_async", mem_req, 0);
    dq.delete(); drop_d(); model_reset();
    mcnt = 0; mem_ready = 0;
    @(posedge clk); #1;
    chk("t5_no_done_in_rst", d_done, 0);
    @(negedge clk); reset = 1;
    clear_log();
    repeat (4) step();
    chk("t5_no_done", n_dd, 0);
    chk("t5_idle", mem_req, 0);
    fixed_wait = 0;

`ifdef MEM_ARB_TIMEOUT_EN
    // memory never answers: watchdog ends the transfer
    fixed_wait = 1000;
    dq.push_back('{we: 1'b0, addr: 32'h8000_00C0, wdata: 32'h0, be: 4'hF});
    start();
    drain("t6_drain");
    chk("t6_dd_cyc", dd_cyc, 1 + TO_CYC);
    chk("t6_err_cyc", err_cyc, 1 + TO_CYC);
    chk("t6_rdata", dd_rdata, 32'hDEAD_BEEF);
    fixed_wait = 0;
`endif

    // random traffic with random wait states
    rand_wait = 1;
    clear_log();
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) begin d_b2b = 1'($urandom); i_b2b = 1'($urandom); end
      if (dq.size() < 3 && $urandom_range(0, 2) == 0)
        dq.push_back('{we: 1'($urandom), addr: 32'h8000_0000 | ($urandom & 32'h7FFF_FFFC),
                       wdata: $urandom, be: 4'($urandom)});
      if (iq.size() < 3 && $urandom_range(0, 2) == 0)
        iq.push_back($urandom & 32'h7FFF_FFFC);
      step();
    end
    drain("t7_drain");
    chk("t7_some_traffic", 32'(n_dd > 20 && n_iv > 20), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
